// File: rtl/sha_1_pkg.sv
// Shared constants, state encoding and helpers for the SHA-1 message
// front end (sha_1_msg_ctrl and its block buffer).
package sha_1_pkg;

  localparam int          SHA1_BLK_WORDS  = 16;
  localparam logic [3:0]  SHA1_LEN_IDX_HI = 4'd14;
  localparam logic [3:0]  SHA1_LEN_IDX_LO = 4'd15;
  localparam logic [31:0] SHA1_PAD_WORD   = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_PAD,
    ST_SEND,
    ST_WAIT
  } state_t;

  // Keep the first nbytes bytes of the final message word (nbytes=0 means
  // all four), put the 0x80 marker right after them and zero the rest.
  function automatic logic [31:0] pad_last_word(input logic [31:0] data,
                                                input logic [1:0]  nbytes);
    case (nbytes)
      2'd1:    return {data[31:24], 8'h80, 16'h0000};
      2'd2:    return {data[31:16], 8'h80, 8'h00};
      2'd3:    return {data[31:8],  8'h80};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/sha_1_blk_buf.sv
// 16x32 staging buffer for one SHA-1 block: one write port, one
// combinational read port.
module sha_1_blk_buf
  import sha_1_pkg::*;
(
  input  logic        clk,
  input  logic        we,
  input  logic [3:0]  widx,
  input  logic [31:0] wdata,
  input  logic [3:0]  ridx,
  output logic [31:0] rdata
);

  logic [31:0] mem [SHA1_BLK_WORDS];

  // Word write; every slot is rewritten before the block is read out.
  // NOTE: no reset on the storage array: each word is written before it is
  // ever read, so a reset would add nothing but reset fan-out.
  // NOTE: registers are always updated with <= so every flop samples the
  // pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/sha_1_msg_ctrl.sv
// SHA-1 message front end: stages a big-endian word stream into 16-word
// blocks, appends SHA-1 padding and the 64-bit bit length, feeds each block
// to sha_1_core as a 16-cycle burst and returns the final digest.
module sha_1_msg_ctrl
  import sha_1_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  s_data,
  input  logic         s_vld,
  input  logic         s_last,
  input  logic [1:0]   s_nbytes,
  output logic         s_rdy,
  output logic [31:0]  core_din,
  output logic         core_din_vld,
  output logic         core_use_pre_cv,
  output logic         core_sha_1_end,
  input  logic         core_busy,
  input  logic [159:0] core_dout,
  input  logic         core_dout_vld,
  output logic [159:0] digest,
  output logic         digest_vld
);

  state_t           state;
  logic [3:0]       widx;
  logic [3:0]       ridx;
  logic [LEN_W-1:0] byte_cnt;
  logic             first_blk;    // next block starts a new message
  logic             final_blk;    // block in flight carries the length
  logic             more_pad;     // another pad-only block follows this one
  logic             pad_pending;  // 0x80 marker word still owed
  logic             spill;        // marker landed at 14/15: no room for length
  logic             bursting;
  logic             seen_busy;

  logic             accept;
  logic             buf_we;
  logic [31:0]      buf_wdata;
  logic [31:0]      buf_rdata;
  logic [31:0]      pad_word;
  logic [2:0]       add_bytes;
  logic [LEN_W:0]   cnt_sum;
  logic [63:0]      bit_len;

  assign s_rdy  = (state == ST_FILL) && !rst;
  assign accept = s_vld && s_rdy;

  assign add_bytes = (s_last && s_nbytes != 2'd0) ? {1'b0, s_nbytes} : 3'd4;
  assign cnt_sum   = {1'b0, byte_cnt} + (LEN_W+1)'(add_bytes);
  assign bit_len   = 64'(byte_cnt) << 3;

  // Select what goes into the buffer this cycle: message words while
  // filling, marker / zero / length words while padding.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    buf_we    = 1'b0;
    buf_wdata = s_data;
    pad_word  = 32'h0;
    if (pad_pending)                  pad_word = SHA1_PAD_WORD;
    else if (spill)                   pad_word = 32'h0;
    else if (widx == SHA1_LEN_IDX_HI) pad_word = bit_len[63:32];
    else if (widx == SHA1_LEN_IDX_LO) pad_word = bit_len[31:0];
    case (state)
      ST_FILL: begin
        buf_we    = accept;
        buf_wdata = s_last ? pad_last_word(s_data, s_nbytes) : s_data;
      end
      ST_PAD: begin
        buf_we    = !rst;
        buf_wdata = pad_word;
      end
      default: ;
    endcase
  end

  sha_1_blk_buf u_buf (
    .clk   (clk),
    .we    (buf_we),
    .widx  (widx),
    .wdata (buf_wdata),
    .ridx  (ridx),
    .rdata (buf_rdata)
  );

  // Block sequencer: fill, pad, burst to the core, then wait for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_FILL;
      widx            <= 4'd0;
      ridx            <= 4'd0;
      byte_cnt        <= '0;
      first_blk       <= 1'b1;
      final_blk       <= 1'b0;
      more_pad        <= 1'b0;
      pad_pending     <= 1'b0;
      spill           <= 1'b0;
      bursting        <= 1'b0;
      seen_busy       <= 1'b0;
      core_din        <= 32'h0;
      core_din_vld    <= 1'b0;
      core_use_pre_cv <= 1'b0;
      core_sha_1_end  <= 1'b0;
      digest          <= 160'h0;
      digest_vld      <= 1'b0;
    end else begin
      core_din_vld    <= 1'b0;
      core_use_pre_cv <= 1'b0;
      core_sha_1_end  <= 1'b0;
      digest_vld      <= 1'b0;
      case (state)
        ST_FILL: begin
          if (accept) begin
            widx     <= widx + 4'd1;
            byte_cnt <= cnt_sum[LEN_W] ? '1 : cnt_sum[LEN_W-1:0];
            if (s_last) begin
              pad_pending <= (s_nbytes == 2'd0);
              if (widx == SHA1_LEN_IDX_LO) begin
                // Message filled the block: all padding goes in the next one.
                final_blk <= 1'b0;
                more_pad  <= 1'b1;
                state     <= ST_SEND;
              end else begin
                spill <= (widx == SHA1_LEN_IDX_HI) && (s_nbytes != 2'd0);
                state <= ST_PAD;
              end
            end else if (widx == SHA1_LEN_IDX_LO) begin
              final_blk <= 1'b0;
              more_pad  <= 1'b0;
              state     <= ST_SEND;
            end
          end
        end
        ST_PAD: begin
          widx        <= widx + 4'd1;
          pad_pending <= 1'b0;
          if (widx == SHA1_LEN_IDX_LO) begin
            final_blk <= !(pad_pending || spill);
            more_pad  <= pad_pending || spill;
            spill     <= 1'b0;
            state     <= ST_SEND;
          end else if (pad_pending && widx == SHA1_LEN_IDX_HI) begin
            spill <= 1'b1;
          end
        end
        ST_SEND: begin
          // Start only on an idle core; once started the burst runs to 16.
          if (bursting || !core_busy) begin
            core_din        <= buf_rdata;
            core_din_vld    <= 1'b1;
            core_use_pre_cv <= !first_blk;
            core_sha_1_end  <= final_blk;
            ridx            <= ridx + 4'd1;
            seen_busy       <= bursting && (seen_busy || core_busy);
            if (ridx == SHA1_LEN_IDX_LO) begin
              bursting <= 1'b0;
              state    <= ST_WAIT;
            end else begin
              bursting <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (final_blk) begin
            if (core_dout_vld) begin
              digest     <= core_dout;
              digest_vld <= 1'b1;
              byte_cnt   <= '0;
              first_blk  <= 1'b1;
              widx       <= 4'd0;
              state      <= ST_FILL;
            end
          end else if (core_busy) begin
            seen_busy <= 1'b1;
          end else if (seen_busy) begin
            first_blk <= 1'b0;
            widx      <= 4'd0;
            state     <= more_pad ? ST_PAD : ST_FILL;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_1_msg_ctrl.sv
// Self-checking bench for sha_1_msg_ctrl: a byte-level SHA-1 padding model
// predicts every core word and digest; a small core model answers bursts
// with real SHA-1 compression; literal digests pin the model.
module tb_sha_1_msg_ctrl;

  typedef byte unsigned bq_t[$];
  typedef struct packed {
    logic [31:0] word;
    logic        pre;
    logic        fin;
  } exp_t;

  localparam logic [159:0] H_INIT  = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
  localparam logic [159:0] DIG_ABC = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] DIG_56  = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  s_data = 32'h0;
  logic         s_vld = 1'b0;
  logic         s_last = 1'b0;
  logic [1:0]   s_nbytes = 2'd0;
  logic         s_rdy;
  logic [31:0]  core_din;
  logic         core_din_vld;
  logic         core_use_pre_cv;
  logic         core_sha_1_end;
  logic         core_busy;
  logic [159:0] core_dout = 160'h0;
  logic         core_dout_vld = 1'b0;
  logic [159:0] digest;
  logic         digest_vld;

  logic         model_busy = 1'b0;
  logic         force_busy = 1'b0;

  int           n_checks = 0;
  int           n_fail = 0;
  exp_t         exp_q[$];
  logic [159:0] dig_q[$];
  int           run = 0;
  logic [31:0]  cap [16];
  logic [31:0]  last_blk [16];

  always #5 clk = ~clk;

  assign core_busy = model_busy | force_busy;

  sha_1_msg_ctrl #(.LEN_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .s_data          (s_data),
    .s_vld           (s_vld),
    .s_last          (s_last),
    .s_nbytes        (s_nbytes),
    .s_rdy           (s_rdy),
    .core_din        (core_din),
    .core_din_vld    (core_din_vld),
    .core_use_pre_cv (core_use_pre_cv),
    .core_sha_1_end  (core_sha_1_end),
    .core_busy       (core_busy),
    .core_dout       (core_dout),
    .core_dout_vld   (core_dout_vld),
    .digest          (digest),
    .digest_vld      (digest_vld)
  );

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expired(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired before the expected event", name);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [159:0] sha1_compress(input logic [159:0] h, input logic [511:0] blk);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 80; i++) begin
      t    = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {t[30:0], t[31]};
    end
    a = h[159:128]; b = h[127:96]; c = h[95:64]; d = h[63:32]; e = h[31:0];
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
      else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
      else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
    end
    return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
  endfunction

  function automatic bq_t str2bytes(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Reference: pad the byte message, queue every core word with its flags,
  // and queue the digest it must produce.
  task automatic model_msg(input bq_t msg);
    bq_t              p;
    longint unsigned  bits;
    logic [511:0]     blk;
    logic [159:0]     h;
    logic [31:0]      wd;
    exp_t             e;
    int               nblk;
    p    = msg;
    bits = longint'(msg.size()) * 8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8*i)));
    nblk = p.size() / 64;
    h    = H_INIT;
    for (int b = 0; b < nblk; b++) begin
      for (int w = 0; w < 16; w++) begin
        wd     = {p[b*64+4*w], p[b*64+4*w+1], p[b*64+4*w+2], p[b*64+4*w+3]};
        e.word = wd;
        e.pre  = (b != 0);
        e.fin  = (b == nblk - 1);
        exp_q.push_back(e);
        blk[511-32*w -: 32] = wd;
      end
      h = sha1_compress(h, blk);
    end
    dig_q.push_back(h);
  endtask

  // Drive a message word by word; unused lanes of the last word carry junk
  // that the controller must overwrite.
  task automatic send_msg(input bq_t msg);
    logic [31:0] data;
    int          nw;
    int          t;
    model_msg(msg);
    nw = (msg.size() + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      data = 32'hEEEE_EEEE;
      for (int k = 0; k < 4; k++)
        if (4*w + k < msg.size()) data[31-8*k -: 8] = msg[4*w+k];
      s_data   = data;
      s_vld    = 1'b1;
      s_last   = (w == nw - 1);
      s_nbytes = 2'(msg.size() % 4);
      t = 0;
      while (!s_rdy && t < 400) begin step(); t++; end
      if (t >= 400) expired("s_rdy_wait");
      step();
    end
    s_vld  = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while ((exp_q.size() != 0 || dig_q.size() != 0) && t < 2000) begin step(); t++; end
    if (t >= 2000) expired("drain");
  endtask

  // Core model: collects bursts, compresses, holds busy, pulses dout_vld
  // after the final block.
  int           cm_cnt = 0;
  int           cm_timer = 0;
  logic         cm_pre = 1'b0;
  logic         cm_fin = 1'b0;
  logic [511:0] cm_blk = '0;
  logic [159:0] cm_h = '0;
  always @(negedge clk) begin
    core_dout_vld = 1'b0;
    if (rst) begin
      cm_cnt = 0; cm_timer = 0; model_busy = 1'b0;
    end else if (core_din_vld) begin
      cm_blk[511-32*cm_cnt -: 32] = core_din;
      cm_pre     = core_use_pre_cv;
      cm_fin     = core_sha_1_end;
      model_busy = 1'b1;
      cm_cnt++;
      if (cm_cnt == 16) begin
        cm_cnt   = 0;
        cm_h     = sha1_compress(cm_pre ? cm_h : H_INIT, cm_blk);
        cm_timer = 6;
      end
    end else if (cm_timer > 0) begin
      cm_timer--;
      if (cm_timer == 0) begin
        model_busy = 1'b0;
        if (cm_fin) begin
          core_dout     = cm_h;
          core_dout_vld = 1'b1;
        end
      end
    end
  end

  // Compare every burst word, flag and digest against the model.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      run = 0;
    end else begin
      if (core_din_vld) begin
        run++;
        if (run <= 16) cap[run-1] = core_din;
        if (run == 16) last_blk = cap;
        check("s_rdy_low_in_send", s_rdy, 1'b0);
        if (exp_q.size() == 0) begin
          expired("unexpected_core_din");
        end else begin
          e = exp_q.pop_front();
          check("core_din", core_din, e.word);
          check("core_use_pre_cv", core_use_pre_cv, e.pre);
          check("core_sha_1_end", core_sha_1_end, e.fin);
        end
      end else if (run != 0) begin
        check("burst_len", run, 16);
        run = 0;
      end
      if (digest_vld) begin
        if (dig_q.size() == 0) expired("unexpected_digest_vld");
        else check("digest", digest, dig_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t m;
    int  t;
    int  vld_cnt;

    // Reset state.
    repeat (3) step();
    check("rst_s_rdy", s_rdy, 1'b0);
    check("rst_core_din_vld", core_din_vld, 1'b0);
    check("rst_core_din", core_din, 32'h0);
    check("rst_flags", {core_use_pre_cv, core_sha_1_end}, 2'b00);
    check("rst_digest", digest, 160'h0);
    check("rst_digest_vld", digest_vld, 1'b0);
    rst = 1'b0;
    step();
    check("s_rdy_after_rst", s_rdy, 1'b1);

    // "abc": single block, length in word 15.
    send_msg(str2bytes("abc"));
    wait_done();
    check("abc_w0", last_blk[0], 32'h6162_6380);
    check("abc_w15", last_blk[15], 32'h0000_0018);
    check("abc_digest", digest, DIG_ABC);

    // 52 bytes ending on a full word: marker in its own word.
    m = {};
    m.push_back(8'hf1); m.push_back(8'hf1); m.push_back(8'hf1); m.push_back(8'hce);
    for (int i = 0; i < 12; i++) begin
      m.push_back(8'hf1); m.push_back(8'hf1); m.push_back(8'hf1); m.push_back(8'hf2);
    end
    send_msg(m);
    wait_done();
    check("m52_w13", last_blk[13], 32'h8000_0000);
    check("m52_w14", last_blk[14], 32'h0);
    check("m52_w15", last_blk[15], 32'h0000_01a0);

    // 56 bytes: length spills into a second block.
    send_msg(str2bytes("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"));
    wait_done();
    check("m56_blk2_w0", last_blk[0], 32'h0);
    check("m56_blk2_w15", last_blk[15], 32'h0000_01c0);
    check("m56_digest", digest, DIG_56);

    // 64 bytes: second block is marker, zeros, length.
    m = {};
    for (int i = 0; i < 64; i++) m.push_back(8'(i + 8'h30));
    send_msg(m);
    wait_done();
    check("m64_blk2_w0", last_blk[0], 32'h8000_0000);
    check("m64_blk2_w1", last_blk[1], 32'h0);
    check("m64_blk2_w15", last_blk[15], 32'h0000_0200);

    // Back-to-back: next message held valid through SEND/WAIT backpressure.
    send_msg(m);
    send_msg(str2bytes("abc"));
    wait_done();
    check("b2b_abc_digest", digest, DIG_ABC);

    // Marker/length placement boundaries.
    for (int n = 55; n <= 62; n++) begin
      m = {};
      for (int i = 0; i < n; i++) m.push_back(8'(8'h41 + i));
      send_msg(m);
      wait_done();
    end

    // Core busy at SEND entry: no valid words until it drops.
    force_busy = 1'b1;
    send_msg(str2bytes("abc"));
    vld_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (core_din_vld) vld_cnt++;
    end
    check("busy_holds_send", vld_cnt, 0);
    force_busy = 1'b0;
    wait_done();
    check("busy_abc_digest", digest, DIG_ABC);

    // Reset in the middle of a burst.
    send_msg(str2bytes("abc"));
    t = 0;
    while (run != 7 && t < 500) begin step(); t++; end
    if (t >= 500) expired("burst_start");
    rst = 1'b1;
    step();
    check("rst_mid_send_vld", core_din_vld, 1'b0);
    rst = 1'b0;
    exp_q.delete();
    dig_q.delete();
    step();
    check("s_rdy_after_mid_rst", s_rdy, 1'b1);
    send_msg(str2bytes("abc"));
    wait_done();
    check("post_rst_abc_digest", digest, DIG_ABC);

    repeat (5) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
